// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared definitions for the run controller that sits between the board-level
// clock/reset and Main_Processor.
//   - run_state_e : controller state encoding (IDLE, HOLD, RUN, DONE)
//   - DEF_*       : default parameter values for the controller
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

  localparam int unsigned DEF_CYCLE_W     = 8;
  localparam int unsigned DEF_HOLD_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

endpackage : run_ctrl_pkg

// File: rtl/run_controller.sv
// -----------------------------------------------------------------------------
// run_controller
// Turns a start request into a reset-hold of HOLD_CYCLES cycles, then a run
// window in which the processor clock enable is high, and finally a one-cycle
// completion pulse. The run ends on a cycle budget or a processor halt request.
//
// Ports
//   Clk         in   single clock, rising edge
//   Reset       in   asynchronous, active-low reset of this block
//   Start       in   run request, sampled only in IDLE
//   Budget      in   enabled cycles to run (0 = halt-only), latched on Start
//   Halt_Req    in   processor halt request, honored only in RUN
//   Cpu_Reset   out  active-high reset to Main_Processor
//   Cpu_En      out  clock enable for processor state elements
//   Busy        out  high in HOLD, RUN and DONE
//   Done        out  one-cycle pulse at the end of a run
//   Cycles      out  enabled cycles executed in the current/last run
//   dbg_state_o out  current controller state, for observation only
//
// Handshake: Start is a level request with no ready; it is accepted on any
// rising edge where the controller is in IDLE and ignored otherwise. Done is
// a single-cycle pulse with no acknowledge.
//
// All status outputs are flops loaded from the decode of the next state, so
// they are glitch-free and line up exactly with the state register.
// -----------------------------------------------------------------------------
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned CYCLE_W     = DEF_CYCLE_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [CYCLE_W-1:0] Budget,
  input  logic               Halt_Req,
  output logic               Cpu_Reset,
  output logic               Cpu_En,
  output logic               Busy,
  output logic               Done,
  output logic [CYCLE_W-1:0] Cycles,
  output run_state_e         dbg_state_o
);

  // Hold counter only ever needs to reach HOLD_CYCLES.
  localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
  localparam logic [CYCLE_W-1:0] CYC_ONE   = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] CYC_ZERO  = '0;
  localparam logic [CYCLE_W-1:0] CYC_MAX   = '1;

  run_state_e         state_q,     state_d;
  logic [CYCLE_W-1:0] budget_q,    budget_d;
  logic [CYCLE_W-1:0] cycles_q,    cycles_d;
  logic [HOLD_W-1:0]  hold_q,      hold_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_en_q,    cpu_en_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  logic               budget_hit;

  // Budget of zero disables the budget stop entirely (halt-only run).
  assign budget_hit = (budget_q != CYC_ZERO) && (cycles_q == (budget_q - CYC_ONE));

  // ---------------------------------------------------------------------------
  // Next-state, counters and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    cycles_d = cycles_q;
    hold_d   = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d  = ST_HOLD;
          budget_d = Budget;
          cycles_d = CYC_ZERO;
          hold_d   = '0;
        end
      end

      ST_HOLD: begin
        hold_d = hold_q + HOLD_ONE;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Every RUN cycle is an executed cycle, including the one that exits.
        // Saturate so a long halt-only run never wraps back to a small count.
        if (cycles_q != CYC_MAX) begin
          cycles_d = cycles_q + CYC_ONE;
        end
        if (Halt_Req || budget_hit) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore decode of the state being entered, registered below.
    cpu_reset_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    cpu_en_d    = (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      budget_q    <= '0;
      cycles_q    <= '0;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      budget_q    <= budget_d;
      cycles_q    <= cycles_d;
      hold_q      <= hold_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Cpu_Reset   = cpu_reset_q;
  assign Cpu_En      = cpu_en_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Cycles      = cycles_q;
  assign dbg_state_o = state_q;

endmodule : run_controller
